majority_voter_pipe: RTL and testbench

- Parametrised, pipelined N-input, WIDTH-bit bitwise majority voter with valid/ready streaming.
- Tracks per-input disagreement history and raises sticky fault flags.
- Optionally excludes faulted inputs from later votes (self-healing N-modular redundancy).
- Sits between replicated compute lanes and the consumer of the voted result; it is the sequential successor of the team's 5-input combinational majority benchmark.

---
 rtl/majority_pkg.sv | 54 +++++
 rtl/majority_fault_tracker.sv | 63 ++++++
 rtl/majority_voter_pipe.sv | 158 +++++++++++++++
 tb/tb_majority_voter_pipe.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/majority_pkg.sv
`default_nettype none
//=============================================================================
// Module      : majority_pkg
// Description : Shared widths and helper functions for the pipelined
//               N-modular-redundancy majority voter.
// Revision    : 1.0 - initial release
//=============================================================================
package majority_pkg;

   // Upper bounds used by the fixed-width helper functions below.
   localparam int MAX_IN = 16;
   localparam int MAX_W  = 64;
   localparam int BUS_W  = MAX_IN * MAX_W;

   // Number of bits needed to hold values 0..value-1.
   function automatic int clog2(input int value);
      int result;
      result = 0;
      for (int k = 0; k < 31; k++) begin
         if ((1 << k) < value) result = k + 1;
      end
      return result;
   endfunction

   // Counter widths for the default configuration (5 lanes, limit 4).
   // Modules derive their own widths from their actual parameters.
   localparam int DEF_NUM_IN      = 5;
   localparam int DEF_FAULT_LIMIT = 4;
   localparam int CNT_W           = clog2(DEF_NUM_IN + 1);
   localparam int FCNT_W          = clog2(DEF_FAULT_LIMIT + 1);

   // Extract lane 'lane' of 'width' bits from a zero-extended packed bus.
   function automatic logic [MAX_W-1:0] lane_extract(input logic [BUS_W-1:0] bus,
                                                     input int lane,
                                                     input int width);
      logic [BUS_W-1:0] shifted;
      logic [MAX_W-1:0] mask;
      shifted = bus >> (lane * width);
      mask    = (width >= MAX_W) ? '1 : ((MAX_W'(1) << width) - MAX_W'(1));
      return shifted[MAX_W-1:0] & mask;
   endfunction

   // Population count of a lane mask.
   function automatic logic [4:0] popcount(input logic [MAX_IN-1:0] v);
      logic [4:0] n;
      n = '0;
      for (int k = 0; k < MAX_IN; k++) begin
         n = n + {4'd0, v[k]};
      end
      return n;
   endfunction

endpackage
`default_nettype wire

// File: rtl/majority_fault_tracker.sv
`default_nettype none
//=============================================================================
// Module      : majority_fault_tracker
// Description : Per-lane consecutive-disagreement counters with sticky fault
//               flags. One update per vote; fault_clr wipes everything.
// Revision    : 1.0 - initial release
//=============================================================================
module majority_fault_tracker
   import majority_pkg::*;
#(
   parameter int NUM_IN      = 5,
   parameter int FAULT_LIMIT = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              update,
   input  logic [NUM_IN-1:0] active,
   input  logic [NUM_IN-1:0] mismatch,
   input  logic              fault_clr,
   output logic [NUM_IN-1:0] fault
);

   localparam int FCNT_BITS = clog2(FAULT_LIMIT + 1);
   localparam logic [FCNT_BITS-1:0] LIMIT = FCNT_BITS'(FAULT_LIMIT);

   logic [NUM_IN-1:0][FCNT_BITS-1:0] cnt;
   logic [NUM_IN-1:0][FCNT_BITS-1:0] cnt_nxt;
   logic [NUM_IN-1:0]                fault_nxt;

   // Next counter/flag values: clear wins, excluded lanes stay frozen.
   always_comb begin
      cnt_nxt   = cnt;
      fault_nxt = fault;
      if (fault_clr) begin
         cnt_nxt   = '0;
         fault_nxt = '0;
      end else if (update) begin
         for (int i = 0; i < NUM_IN; i++) begin
            if (active[i]) begin
               if (mismatch[i]) begin
                  if (cnt[i] != LIMIT) cnt_nxt[i] = cnt[i] + FCNT_BITS'(1);
                  if (cnt_nxt[i] == LIMIT) fault_nxt[i] = 1'b1;
               end else begin
                  cnt_nxt[i] = '0;
               end
            end
         end
      end
   end

   // Counter and sticky flag registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt   <= '0;
         fault <= '0;
      end else begin
         cnt   <= cnt_nxt;
         fault <= fault_nxt;
      end
   end

endmodule
`default_nettype wire

// File: rtl/majority_voter_pipe.sv
`default_nettype none
//=============================================================================
// Module      : majority_voter_pipe
// Description : Two-stage pipelined NUM_IN x WIDTH bitwise majority voter
//               with valid/ready streaming, per-lane fault tracking and
//               optional exclusion of faulted lanes from later votes.
//               Legal: NUM_IN 3..15, FAULT_LIMIT 1..255, WIDTH <= 64.
// Revision    : 1.0 - initial release
//=============================================================================
module majority_voter_pipe
   import majority_pkg::*;
#(
   parameter int NUM_IN       = 5,
   parameter int WIDTH        = 8,
   parameter int FAULT_LIMIT  = 4,
   parameter int AUTO_EXCLUDE = 1
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [NUM_IN*WIDTH-1:0] in_data,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [WIDTH-1:0]        out_data,
   output logic                    out_unanimous,
   output logic                    out_no_quorum,
   output logic [NUM_IN-1:0]       fault,
   input  logic                    fault_clr
);

   // Width of a per-bit ones count and of the active-lane count.
   localparam int ONES_W = clog2(NUM_IN + 1);
   localparam int PAD_W  = BUS_W - NUM_IN * WIDTH;

   // Handshake
   logic s1_load;
   logic s2_load;

   // Input-side combinational vote preparation
   logic [NUM_IN-1:0]             active;
   logic [WIDTH-1:0][MAX_IN-1:0]  col;
   logic [WIDTH-1:0][ONES_W-1:0]  ones;
   logic [ONES_W-1:0]             n_active;

   // Stage 1 registers
   logic                          s1_valid;
   logic [NUM_IN*WIDTH-1:0]       s1_data;
   logic [NUM_IN-1:0]             s1_active;
   logic [WIDTH-1:0][ONES_W-1:0]  s1_ones;
   logic [ONES_W-1:0]             s1_nact;

   // Stage 1 -> stage 2 combinational result
   logic [BUS_W-1:0]              s1_bus;
   logic [WIDTH-1:0]              vote;
   logic [NUM_IN-1:0]             mismatch;
   logic                          unanimous_nxt;
   logic                          no_quorum_nxt;

   assign s2_load  = s1_valid & (~out_valid | out_ready);
   assign in_ready = ~s1_valid | s2_load;
   assign s1_load  = in_valid & in_ready;

   // A faulted lane leaves the vote only when exclusion is enabled.
   assign active = (AUTO_EXCLUDE != 0) ? ~fault : '1;

   // Gather bit column b across all active lanes.
   always_comb begin
      col = '0;
      for (int b = 0; b < WIDTH; b++) begin
         for (int i = 0; i < NUM_IN; i++) begin
            col[b][i] = in_data[i*WIDTH + b] & active[i];
         end
      end
   end

   generate
      for (genvar b = 0; b < WIDTH; b++) begin : g_ones
         assign ones[b] = ONES_W'(popcount(col[b]));
      end
   endgenerate

   assign n_active = ONES_W'(popcount(MAX_IN'(active)));

   // Stage 1: capture the beat, its lane mask and the per-bit counts.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid  <= 1'b0;
         s1_data   <= '0;
         s1_active <= '0;
         s1_ones   <= '0;
         s1_nact   <= '0;
      end else begin
         if (s1_load) begin
            s1_valid  <= 1'b1;
            s1_data   <= in_data;
            s1_active <= active;
            s1_ones   <= ones;
            s1_nact   <= n_active;
         end else if (s2_load) begin
            s1_valid  <= 1'b0;
         end
      end
   end

   // Strict majority per bit; ties and an empty quorum give 0.
   always_comb begin
      vote = '0;
      for (int b = 0; b < WIDTH; b++) begin
         vote[b] = {s1_ones[b], 1'b0} > {1'b0, s1_nact};
      end
   end

   assign s1_bus = {{PAD_W{1'b0}}, s1_data};

   generate
      for (genvar i = 0; i < NUM_IN; i++) begin : g_lane
         assign mismatch[i] = WIDTH'(lane_extract(s1_bus, i, WIDTH)) != vote;
      end
   endgenerate

   assign no_quorum_nxt = (s1_nact == '0);
   assign unanimous_nxt = ~no_quorum_nxt & ~|(mismatch & s1_active);

   // Stage 2: voted result register, held while the consumer stalls.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid     <= 1'b0;
         out_data      <= '0;
         out_unanimous <= 1'b0;
         out_no_quorum <= 1'b0;
      end else begin
         if (s2_load) begin
            out_valid     <= 1'b1;
            out_data      <= vote;
            out_unanimous <= unanimous_nxt;
            out_no_quorum <= no_quorum_nxt;
         end else if (out_ready) begin
            out_valid     <= 1'b0;
         end
      end
   end

   majority_fault_tracker #(
      .NUM_IN      (NUM_IN),
      .FAULT_LIMIT (FAULT_LIMIT)
   ) u_fault_tracker (
      .clk       (clk),
      .rst_n     (rst_n),
      .update    (s2_load),
      .active    (s1_active),
      .mismatch  (mismatch),
      .fault_clr (fault_clr),
      .fault     (fault)
   );

endmodule
`default_nettype wire

// File: tb/tb_majority_voter_pipe.sv
`default_nettype none
//=============================================================================
// Module      : tb_majority_voter_pipe
// Description : Directed, table-driven bench for majority_voter_pipe
//               (5 lanes x 8 bits, fault limit 4, auto-exclude on).
// Revision    : 1.0 - initial release
//=============================================================================
module tb_majority_voter_pipe;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [39:0] in_data;
   logic        out_valid;
   logic        out_ready;
   logic [7:0]  out_data;
   logic        out_unanimous;
   logic        out_no_quorum;
   logic [4:0]  fault;
   logic        fault_clr;

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic        clr;
      logic [39:0] lanes;
      logic [7:0]  d;
      logic        u;
      logic        n;
      logic [4:0]  f;
   } vec_t;

   vec_t vecs[$];

   majority_voter_pipe #(
      .NUM_IN       (5),
      .WIDTH        (8),
      .FAULT_LIMIT  (4),
      .AUTO_EXCLUDE (1)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .in_data       (in_data),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .out_data      (out_data),
      .out_unanimous (out_unanimous),
      .out_no_quorum (out_no_quorum),
      .fault         (fault),
      .fault_clr     (fault_clr)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string nm, input logic [39:0] act, input logic [39:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   function automatic logic [39:0] lanes5(input logic [7:0] l0, l1, l2, l3, l4);
      return {l4, l3, l2, l1, l0};
   endfunction

   task automatic add(input logic clr, input logic [39:0] l, input logic [7:0] d,
                      input logic u, input logic n, input logic [4:0] f);
      vec_t v;
      v.clr = clr; v.lanes = l; v.d = d; v.u = u; v.n = n; v.f = f;
      vecs.push_back(v);
   endtask

   task automatic pulse_clr;
      fault_clr = 1'b1;
      tick;
      fault_clr = 1'b0;
   endtask

   // One isolated beat with out_ready high: accepted on edge 1, valid after edge 2.
   task automatic send_check(input logic [39:0] lanes, input logic [7:0] ed, input logic eu,
                             input logic en, input logic [4:0] ef, input string nm);
      in_valid = 1'b1;
      in_data  = lanes;
      check({nm, " in_ready"}, 40'(in_ready), 40'(1'b1));
      tick;
      in_valid = 1'b0;
      check({nm, " early valid"}, 40'(out_valid), 40'(1'b0));
      tick;
      check({nm, " out_valid"}, 40'(out_valid), 40'(1'b1));
      check({nm, " out_data"}, 40'(out_data), 40'(ed));
      check({nm, " unanimous"}, 40'(out_unanimous), 40'(eu));
      check({nm, " no_quorum"}, 40'(out_no_quorum), 40'(en));
      check({nm, " fault"}, 40'(fault), 40'(ef));
   endtask

   initial begin
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_data   = '0;
      out_ready = 1'b1;
      fault_clr = 1'b0;

      // Vote table: isolated beats, expected values worked out by hand.
      add(1, lanes5(8'hA5, 8'hA5, 8'hA5, 8'h00, 8'hFF), 8'hA5, 0, 0, 5'b00000);
      add(0, lanes5(8'h3C, 8'h3C, 8'h3C, 8'h3C, 8'h3C), 8'h3C, 1, 0, 5'b00000);
      add(0, lanes5(8'hFF, 8'hFF, 8'hFF, 8'h00, 8'h00), 8'hFF, 0, 0, 5'b00000);
      add(0, lanes5(8'h01, 8'h02, 8'h04, 8'h08, 8'h10), 8'h00, 0, 0, 5'b00000);
      add(0, lanes5(8'h5A, 8'h5A, 8'h5A, 8'h5A, 8'h5A), 8'h5A, 1, 0, 5'b00000);
      add(0, lanes5(8'hF0, 8'hF0, 8'h0F, 8'h0F, 8'hFF), 8'hFF, 0, 0, 5'b00000);
      add(0, lanes5(8'h00, 8'h00, 8'h00, 8'h00, 8'h00), 8'h00, 1, 0, 5'b00000);
      add(0, lanes5(8'h81, 8'h81, 8'h81, 8'h81, 8'h7E), 8'h81, 0, 0, 5'b00000);
      // lane 4 disagrees four times in a row, then is excluded
      for (int k = 0; k < 4; k++)
         add(k == 0, lanes5(8'h11, 8'h11, 8'h11, 8'h11, 8'h3C), 8'h11, 0, 0,
             (k == 3) ? 5'b10000 : 5'b00000);
      add(0, lanes5(8'h0F, 8'h0F, 8'hF0, 8'hF0, 8'hFF), 8'h00, 0, 0, 5'b10000);
      add(0, lanes5(8'h11, 8'h11, 8'h11, 8'h11, 8'h3C), 8'h11, 1, 0, 5'b10000);
      // fault lanes down to an empty quorum
      for (int k = 0; k < 4; k++)
         add(k == 0, lanes5(8'h11, 8'h11, 8'h11, 8'h22, 8'h22), 8'h11, 0, 0,
             (k == 3) ? 5'b11000 : 5'b00000);
      for (int k = 0; k < 4; k++)
         add(0, lanes5(8'h11, 8'h11, 8'h22, 8'h22, 8'h22), 8'h11, 0, 0,
             (k == 3) ? 5'b11100 : 5'b11000);
      for (int k = 0; k < 4; k++)
         add(0, lanes5(8'h11, 8'h22, 8'h22, 8'h22, 8'h22), 8'h00, 0, 0,
             (k == 3) ? 5'b11111 : 5'b11100);
      add(0, lanes5(8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF), 8'h00, 0, 1, 5'b11111);

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      check("reset out_valid", 40'(out_valid), 40'(1'b0));
      check("reset out_data", 40'(out_data), 40'(8'h00));
      check("reset unanimous", 40'(out_unanimous), 40'(1'b0));
      check("reset no_quorum", 40'(out_no_quorum), 40'(1'b0));
      check("reset fault", 40'(fault), 40'(5'b00000));
      check("reset in_ready", 40'(in_ready), 40'(1'b1));
      tick;

      foreach (vecs[r]) begin
         if (vecs[r].clr) pulse_clr;
         send_check(vecs[r].lanes, vecs[r].d, vecs[r].u, vecs[r].n, vecs[r].f,
                    $sformatf("vec%0d", r));
      end

      // Backpressure: three beats, consumer stalled; lane 4 disagrees in each.
      pulse_clr;
      check("clr fault", 40'(fault), 40'(5'b00000));
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_data   = lanes5(8'h01, 8'h01, 8'h01, 8'h01, 8'h80);
      check("bp ready b1", 40'(in_ready), 40'(1'b1));
      tick;
      in_data   = lanes5(8'h02, 8'h02, 8'h02, 8'h02, 8'h80);
      check("bp ready b2", 40'(in_ready), 40'(1'b1));
      tick;
      check("bp valid b1", 40'(out_valid), 40'(1'b1));
      check("bp data b1", 40'(out_data), 40'(8'h01));
      in_data   = lanes5(8'h03, 8'h03, 8'h03, 8'h03, 8'h80);
      check("bp ready drop", 40'(in_ready), 40'(1'b0));
      repeat (4) tick;
      check("bp hold valid", 40'(out_valid), 40'(1'b1));
      check("bp hold data", 40'(out_data), 40'(8'h01));
      check("bp hold ready", 40'(in_ready), 40'(1'b0));
      out_ready = 1'b1;
      #1;
      check("bp ready release", 40'(in_ready), 40'(1'b1));
      tick;
      in_valid = 1'b0;
      check("bp valid b2", 40'(out_valid), 40'(1'b1));
      check("bp data b2", 40'(out_data), 40'(8'h02));
      tick;
      check("bp valid b3", 40'(out_valid), 40'(1'b1));
      check("bp data b3", 40'(out_data), 40'(8'h03));
      tick;
      check("bp drained", 40'(out_valid), 40'(1'b0));
      check("bp single count", 40'(fault), 40'(5'b00000));

      // fault_clr colliding with the 4th disagreement of lane 4
      pulse_clr;
      for (int k = 0; k < 3; k++)
         send_check(lanes5(8'h11, 8'h11, 8'h11, 8'h11, 8'h3C), 8'h11, 0, 0, 5'b00000,
                    $sformatf("pre-coll%0d", k));
      in_valid = 1'b1;
      in_data  = lanes5(8'h11, 8'h11, 8'h11, 8'h11, 8'h3C);
      tick;
      in_valid  = 1'b0;
      fault_clr = 1'b1;
      tick;
      fault_clr = 1'b0;
      check("coll valid", 40'(out_valid), 40'(1'b1));
      check("coll data", 40'(out_data), 40'(8'h11));
      check("coll fault", 40'(fault), 40'(5'b00000));
      // counters were cleared too: three more misses stay clean, the 4th flags
      for (int k = 0; k < 4; k++)
         send_check(lanes5(8'h11, 8'h11, 8'h11, 8'h11, 8'h3C), 8'h11, 0, 0,
                    (k == 3) ? 5'b10000 : 5'b00000, $sformatf("post-coll%0d", k));

      // Async reset with both stages full
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_data   = lanes5(8'h55, 8'h55, 8'h55, 8'h55, 8'h55);
      tick;
      in_data   = lanes5(8'hAA, 8'hAA, 8'hAA, 8'hAA, 8'hAA);
      tick;
      in_valid  = 1'b0;
      check("rst pre valid", 40'(out_valid), 40'(1'b1));
      check("rst pre ready", 40'(in_ready), 40'(1'b0));
      #2;
      rst_n = 1'b0;
      #1;
      check("rst async valid", 40'(out_valid), 40'(1'b0));
      check("rst async fault", 40'(fault), 40'(5'b00000));
      check("rst async data", 40'(out_data), 40'(8'h00));
      tick;
      tick;
      rst_n     = 1'b1;
      out_ready = 1'b1;
      tick;
      tick;
      check("rst no stale beat", 40'(out_valid), 40'(1'b0));
      send_check(lanes5(8'h66, 8'h66, 8'h66, 8'h66, 8'h66), 8'h66, 1, 0, 5'b00000, "post-rst");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
